// File: rtl/imem_boot_loader.sv
// Byte-stream boot loader: assembles big-endian 32-bit words into instruction memory,
// verifies an XOR checksum over the image and only then releases the processor.
module imem_boot_loader #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic              start,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_CNT_HI,
        S_CNT_LO,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } loaderState_t;

    loaderState_t state, nextState;

    logic [7:0]  countHi;
    logic [15:0] count;
    logic [15:0] fullCount;
    logic [1:0]  byteIdx;
    logic [23:0] assembler;
    logic [15:0] wordCnt;
    logic [7:0]  csum;
    logic        accept;
    logic        countTooBig;
    logic        lastWord;
    logic        wordComplete;
    logic        csumOk;

    assign in_ready     = (state != S_DONE) && (state != S_ERR);
    assign accept       = in_valid && in_ready;
    assign fullCount    = {countHi, in_data};
    assign countTooBig  = {1'b0, fullCount} > 17'(DEPTH);
    assign lastWord     = (wordCnt + 16'd1) == count;
    assign wordComplete = accept && (byteIdx == 2'd3);
    assign csumOk       = (in_data == csum);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_CNT_HI;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic; the last word's 4th byte moves on to the checksum byte
    always_comb begin
        nextState = state;
        case (state)
            S_CNT_HI: begin
                if (accept) nextState = S_CNT_LO;
            end
            S_CNT_LO: begin
                if (accept) begin
                    if (countTooBig)            nextState = S_ERR;
                    else if (fullCount == 16'd0) nextState = S_CSUM;
                    else                         nextState = S_DATA;
                end
            end
            S_DATA: begin
                if (wordComplete && lastWord) nextState = S_CSUM;
            end
            S_CSUM: begin
                if (accept) nextState = csumOk ? S_DONE : S_ERR;
            end
            S_DONE, S_ERR: begin
                if (start) nextState = S_CNT_HI;
            end
            default: nextState = S_CNT_HI;
        endcase
    end

    // Datapath: count capture, word assembly, memory write port and status flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            countHi   <= 8'd0;
            count     <= 16'd0;
            byteIdx   <= 2'd0;
            assembler <= 24'd0;
            wordCnt   <= 16'd0;
            csum      <= 8'd0;
            im_we     <= 1'b0;
            im_addr   <= '0;
            im_wdata  <= 32'd0;
            cpu_hold  <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            im_we <= 1'b0;
            case (state)
                S_CNT_HI: begin
                    if (accept) begin
                        countHi <= in_data;
                        csum    <= csum ^ in_data;
                    end
                end
                S_CNT_LO: begin
                    if (accept) begin
                        count <= fullCount;
                        csum  <= csum ^ in_data;
                        if (countTooBig) err <= 1'b1;
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        byteIdx   <= byteIdx + 2'd1;
                        assembler <= {assembler[15:0], in_data};
                        csum      <= csum ^ in_data;
                    end
                    if (wordComplete) begin
                        im_wdata <= {assembler, in_data};
                        im_addr  <= wordCnt[ADDR_W-1:0];
                        im_we    <= 1'b1;
                        wordCnt  <= wordCnt + 16'd1;
                    end
                end
                S_CSUM: begin
                    if (accept) begin
                        if (csumOk) begin
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                S_DONE, S_ERR: begin
                    // Restart clears everything except the last memory write values
                    if (start) begin
                        countHi   <= 8'd0;
                        count     <= 16'd0;
                        byteIdx   <= 2'd0;
                        assembler <= 24'd0;
                        wordCnt   <= 16'd0;
                        csum      <= 8'd0;
                        cpu_hold  <= 1'b1;
                        done      <= 1'b0;
                        err       <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: directed images plus random images checked
// against an image-level reference model (parse count, slice words, XOR checksum).
module tb_imem_boot_loader;

    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1024;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = 8'd0;
    logic              in_ready;
    logic              start = 1'b0;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_wdata;
    logic              cpu_hold;
    logic              done;
    logic              err;

    int checks = 0;
    int errors = 0;

    logic [7:0]          image[$];
    logic [ADDR_W+31:0]  captured[$];
    logic [ADDR_W+31:0]  expWrites[$];
    logic                expDone;
    logic                expErr;
    int                  sendLen;

    always #5 clk = ~clk;

    imem_boot_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .start    (start),
        .im_we    (im_we),
        .im_addr  (im_addr),
        .im_wdata (im_wdata),
        .cpu_hold (cpu_hold),
        .done     (done),
        .err      (err)
    );

    // Every write strobe seen between clock edges is logged once
    always @(negedge clk) begin
        if (rst && im_we) captured.push_back({im_addr, im_wdata});
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Reference model: interpret the image as the format defines it
    task automatic buildModel();
        int n;
        logic [7:0] x;
        expWrites.delete();
        n = int'({image[0], image[1]});
        if (n > DEPTH) begin
            expErr  = 1'b1;
            expDone = 1'b0;
            sendLen = 2;
            return;
        end
        x = 8'd0;
        for (int i = 0; i < 2 + 4 * n; i++) x ^= image[i];
        for (int w = 0; w < n; w++)
            expWrites.push_back({ADDR_W'(w), image[2+4*w], image[3+4*w], image[4+4*w], image[5+4*w]});
        expDone = (image[2+4*n] == x);
        expErr  = !expDone;
        sendLen = 3 + 4 * n;
    endtask

    task automatic makeImage(input int n, input bit good);
        logic [7:0] x;
        logic [7:0] b;
        image.delete();
        image.push_back(8'(n >> 8));
        image.push_back(8'(n));
        if (n > DEPTH) return;
        x = image[0] ^ image[1];
        for (int i = 0; i < 4 * n; i++) begin
            b = 8'($urandom);
            image.push_back(b);
            x ^= b;
        end
        image.push_back(good ? x : (x ^ 8'($urandom_range(1, 255))));
    endtask

    task automatic setTest1(input logic [7:0] csumByte);
        image = '{8'h00, 8'h02, 8'h8C, 8'h22, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'hA8};
        image[10] = csumByte;
    endtask

    // gap < 0 means a random 0..3 idle cycles before each byte
    task automatic sendByte(input logic [7:0] b, input int gap, input bit startNoise);
        int idle;
        int waitCnt;
        idle = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
        repeat (idle) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            start    = startNoise ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        waitCnt  = 0;
        while (in_ready !== 1'b1 && waitCnt < 20) begin
            @(negedge clk);
            waitCnt++;
        end
        check("in_ready before byte", 32'(in_ready), 32'd1);
        @(posedge clk);
    endtask

    task automatic applyStimulus(input int gap, input bit startNoise);
        captured.delete();
        buildModel();
        for (int i = 0; i < sendLen; i++) sendByte(image[i], gap, startNoise);
        @(negedge clk);
        in_valid = 1'b0;
        start    = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic checkOutput(input string tag);
        check({tag, " write count"}, 32'(captured.size()), 32'(expWrites.size()));
        for (int i = 0; i < expWrites.size() && i < captured.size(); i++) begin
            check($sformatf("%s addr%0d", tag, i), 32'(captured[i][ADDR_W+31:32]), 32'(expWrites[i][ADDR_W+31:32]));
            check($sformatf("%s data%0d", tag, i), captured[i][31:0], expWrites[i][31:0]);
        end
        check({tag, " done"}, 32'(done), 32'(expDone));
        check({tag, " err"}, 32'(err), 32'(expErr));
        check({tag, " cpu_hold"}, 32'(cpu_hold), 32'(!expDone));
        check({tag, " in_ready"}, 32'(in_ready), 32'd0);
        check({tag, " im_we idle"}, 32'(im_we), 32'd0);
    endtask

    task automatic pulseStart(input string tag);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, " restart done"}, 32'(done), 32'd0);
        check({tag, " restart err"}, 32'(err), 32'd0);
        check({tag, " restart cpu_hold"}, 32'(cpu_hold), 32'd1);
        check({tag, " restart in_ready"}, 32'(in_ready), 32'd1);
    endtask

    task automatic checkResetValues(input string tag);
        check({tag, " in_ready"}, 32'(in_ready), 32'd1);
        check({tag, " im_we"}, 32'(im_we), 32'd0);
        check({tag, " im_addr"}, 32'(im_addr), 32'd0);
        check({tag, " im_wdata"}, im_wdata, 32'd0);
        check({tag, " cpu_hold"}, 32'(cpu_hold), 32'd1);
        check({tag, " done"}, 32'(done), 32'd0);
        check({tag, " err"}, 32'(err), 32'd0);
    endtask

    initial begin
        int n;
        bit good;

        // Power-on reset
        repeat (2) @(negedge clk);
        checkResetValues("por");
        rst = 1'b1;

        // Test 1: two-word image with good checksum
        setTest1(8'hA8);
        applyStimulus(0, 1'b0);
        checkOutput("t1");
        if (captured.size() == 2) begin
            check("t1 word0 literal", captured[0][31:0], 32'h8C220004);
            check("t1 word1 literal", captured[1][31:0], 32'h00000000);
        end
        // Bytes offered in the done state are ignored
        repeat (3) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 8'($urandom);
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("t1 ignored bytes writes", 32'(captured.size()), 32'd2);
        check("t1 ignored bytes done", 32'(done), 32'd1);
        pulseStart("t1");

        // Test 2: bad checksum
        setTest1(8'hA9);
        applyStimulus(0, 1'b0);
        checkOutput("t2");
        pulseStart("t2");

        // Test 3: count of DEPTH+1 rejected after the second byte
        image = '{8'h04, 8'h01};
        applyStimulus(0, 1'b0);
        checkOutput("t3");
        pulseStart("t3");

        // Test 4: empty image, then reload test 1
        image = '{8'h00, 8'h00, 8'h00};
        applyStimulus(0, 1'b0);
        checkOutput("t4 empty");
        pulseStart("t4");
        setTest1(8'hA8);
        applyStimulus(0, 1'b0);
        checkOutput("t4 reload");
        pulseStart("t4 reload");

        // Test 5: three idle cycles between bytes
        setTest1(8'hA8);
        applyStimulus(3, 1'b0);
        checkOutput("t5");
        pulseStart("t5");

        // Test 6: asynchronous reset part-way through a word
        setTest1(8'hA8);
        captured.delete();
        for (int i = 0; i < 5; i++) sendByte(image[i], 0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst = 1'b0;
        #1 checkResetValues("t6 in reset");
        @(negedge clk);
        rst = 1'b1;
        check("t6 no writes", 32'(captured.size()), 32'd0);
        applyStimulus(0, 1'b0);
        checkOutput("t6 resend");
        pulseStart("t6");

        // Boundary: exactly DEPTH words accepted
        makeImage(DEPTH, 1'b1);
        applyStimulus(0, 1'b0);
        checkOutput("depth");
        pulseStart("depth");

        // Random images with random gaps and start noise during loading
        for (int t = 0; t < 20; t++) begin
            if ($urandom_range(0, 7) == 0) n = int'($urandom_range(DEPTH + 1, 65535));
            else                           n = int'($urandom_range(0, 6));
            good = ($urandom_range(0, 3) != 0);
            makeImage(n, good);
            applyStimulus(-1, 1'b1);
            checkOutput($sformatf("rnd%0d", t));
            pulseStart($sformatf("rnd%0d", t));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
